// File: rtl/csr_args_pkg.sv
// rtl/csr_args_pkg.sv - shared types and address map for the csr_args host register file
package csr_args_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam int unsigned CTRL_ADDR   = 32'h00;
    localparam int unsigned CYCLES_ADDR = 32'h04;
    localparam int unsigned ARG_BASE    = 32'h08;

    localparam int CTRL_LAUNCH   = 0;
    localparam int CTRL_FINISH   = 1;
    localparam int CTRL_BUSY     = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_IRQ_PEND = 4;

endpackage

// File: rtl/csr_args_decode.sv
// rtl/csr_args_decode.sv - host byte address to register select decode (combinational)
module csr_args_decode
    import csr_args_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int NUM_ARGS  = 4
) (
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 is_ctrl,
    output logic                 is_cycles,
    output logic [NUM_ARGS-1:0]  arg_sel,
    output logic                 valid
);

    localparam int WORD_BITS = ADDR_BITS - 2;

    logic                 aligned;
    logic [WORD_BITS-1:0] word;

    assign aligned   = (addr[1:0] == 2'b00);
    assign word      = addr[ADDR_BITS-1:2];
    assign is_ctrl   = aligned && (word == WORD_BITS'(CTRL_ADDR / 4));
    assign is_cycles = aligned && (word == WORD_BITS'(CYCLES_ADDR / 4));

    for (genvar k = 0; k < NUM_ARGS; k++) begin : g_arg
        assign arg_sel[k] = aligned && (word == WORD_BITS'(ARG_BASE / 4 + k));
    end

    assign valid = is_ctrl | is_cycles | (|arg_sel);

endmodule

// File: rtl/csr_args.sv
// rtl/csr_args.sv - host CSR file: control/status, run-cycle counter, argument registers; optional irq via CSR_ARGS_IRQ_EN
module csr_args
    import csr_args_pkg::*;
#(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int NUM_ARGS       = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               host_req_valid,
    input  logic                               host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0]          host_req_addr,
    input  logic [HOST_DATA_BITS-1:0]          host_req_value,
    output logic                               host_req_deq,
    output logic                               host_resp_valid,
    output logic [HOST_DATA_BITS-1:0]          host_resp_bits,
    output logic                               launch,
    input  logic                               finish,
    output logic [NUM_ARGS*HOST_DATA_BITS-1:0] args,
    output logic                               irq
);

    localparam int MAX_ARGS = 2 ** (HOST_ADDR_BITS - 2) - 2;

    if (NUM_ARGS < 1 || NUM_ARGS > MAX_ARGS) begin : g_bad_num_args
        $error("csr_args: NUM_ARGS outside 1..%0d", MAX_ARGS);
    end

    state_t                    state_q, state_d;
    logic                      launch_q, launch_d;
    logic                      finish_bit_q, finish_bit_d;
    logic [HOST_DATA_BITS-1:0] cycles_q, cycles_d;
    logic [HOST_DATA_BITS-1:0] args_q [NUM_ARGS];
    logic [HOST_DATA_BITS-1:0] args_d [NUM_ARGS];
    logic                      resp_valid_q, resp_valid_d;
    logic [HOST_DATA_BITS-1:0] resp_bits_q, resp_bits_d;
`ifdef CSR_ARGS_IRQ_EN
    logic                      irq_en_q, irq_en_d;
    logic                      irq_pend_q, irq_pend_d;
    logic                      irq_q, irq_d;
`endif

    logic                      is_ctrl, is_cycles, addr_valid;
    logic [NUM_ARGS-1:0]       arg_sel;
    logic                      accept, wr, rd, ctrl_wr, launch_req;
    logic [HOST_DATA_BITS-1:0] read_data;

    csr_args_decode #(
        .ADDR_BITS (HOST_ADDR_BITS),
        .NUM_ARGS  (NUM_ARGS)
    ) u_decode (
        .addr      (host_req_addr),
        .is_ctrl   (is_ctrl),
        .is_cycles (is_cycles),
        .arg_sel   (arg_sel),
        .valid     (addr_valid)
    );

    assign accept  = (state_q == IDLE) && host_req_valid;
    assign wr      = accept && host_req_opcode;
    assign rd      = accept && !host_req_opcode;
    assign ctrl_wr = wr && is_ctrl;
    // A finish pulse in the same cycle swallows the launch request.
    assign launch_req = ctrl_wr && host_req_value[CTRL_LAUNCH] && !launch_q && !finish;

    always_comb begin
        read_data = '0;
        if (addr_valid) begin
            if (is_ctrl) begin
                read_data[CTRL_LAUNCH] = launch_q;
                read_data[CTRL_FINISH] = finish_bit_q;
                read_data[CTRL_BUSY]   = launch_q;
`ifdef CSR_ARGS_IRQ_EN
                read_data[CTRL_IRQ_EN]   = irq_en_q;
                read_data[CTRL_IRQ_PEND] = irq_pend_q;
`else
                read_data[CTRL_IRQ_EN]   = 1'b0;
                read_data[CTRL_IRQ_PEND] = 1'b0;
`endif
            end else if (is_cycles) begin
                read_data = cycles_q;
            end
            for (int k = 0; k < NUM_ARGS; k++) begin
                if (arg_sel[k]) begin
                    read_data = read_data | args_q[k];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd) state_d = READ;
            READ:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        resp_valid_d = rd;
        resp_bits_d  = rd ? read_data : resp_bits_q;

        cycles_d = (launch_q && (cycles_q != '1)) ? cycles_q + HOST_DATA_BITS'(1) : cycles_q;
        launch_d     = launch_q;
        finish_bit_d = finish_bit_q;
        if (ctrl_wr && host_req_value[CTRL_FINISH]) begin
            finish_bit_d = 1'b0;
        end
        if (launch_req) begin
            launch_d     = 1'b1;
            finish_bit_d = 1'b0;
            cycles_d     = '0;
        end
        if (finish) begin
            launch_d     = 1'b0;
            finish_bit_d = 1'b1;
        end

        for (int k = 0; k < NUM_ARGS; k++) begin
            args_d[k] = (wr && arg_sel[k]) ? host_req_value : args_q[k];
        end

`ifdef CSR_ARGS_IRQ_EN
        irq_en_d   = ctrl_wr ? host_req_value[CTRL_IRQ_EN] : irq_en_q;
        irq_pend_d = irq_pend_q;
        if (ctrl_wr && host_req_value[CTRL_IRQ_PEND]) begin
            irq_pend_d = 1'b0;
        end
        if (finish) begin
            irq_pend_d = 1'b1;
        end
        irq_d = irq_pend_d & irq_en_d;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            launch_q     <= 1'b0;
            finish_bit_q <= 1'b0;
            cycles_q     <= '0;
            args_q       <= '{default: '0};
            resp_valid_q <= 1'b0;
            resp_bits_q  <= '0;
`ifdef CSR_ARGS_IRQ_EN
            irq_en_q     <= 1'b0;
            irq_pend_q   <= 1'b0;
            irq_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            launch_q     <= launch_d;
            finish_bit_q <= finish_bit_d;
            cycles_q     <= cycles_d;
            args_q       <= args_d;
            resp_valid_q <= resp_valid_d;
            resp_bits_q  <= resp_bits_d;
`ifdef CSR_ARGS_IRQ_EN
            irq_en_q     <= irq_en_d;
            irq_pend_q   <= irq_pend_d;
            irq_q        <= irq_d;
`endif
        end
    end

    assign host_req_deq    = accept;
    assign host_resp_valid = resp_valid_q;
    assign host_resp_bits  = resp_bits_q;
    assign launch          = launch_q;
`ifdef CSR_ARGS_IRQ_EN
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    for (genvar k = 0; k < NUM_ARGS; k++) begin : g_args_out
        assign args[k*HOST_DATA_BITS +: HOST_DATA_BITS] = args_q[k];
    end

endmodule

// File: tb/tb_csr_args.sv
// tb/tb_csr_args.sv - self-checking bench for csr_args against a transaction-level register model
module tb_csr_args;

    localparam int NARGS = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               host_req_valid = 1'b0;
    logic               host_req_opcode = 1'b0;
    logic [7:0]         host_req_addr = 8'h00;
    logic [31:0]        host_req_value = 32'h0;
    logic               host_req_deq;
    logic               host_resp_valid;
    logic [31:0]        host_resp_bits;
    logic               launch;
    logic               finish = 1'b0;
    logic [NARGS*32-1:0] args;
    logic               irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_read;
    bit          m_launch;
    bit          m_fin;
    logic [31:0] m_cycles;
    logic [31:0] m_args [NARGS];
    bit          m_resp_valid;
    logic [31:0] m_resp_bits;
`ifdef CSR_ARGS_IRQ_EN
    bit          m_irq_en;
    bit          m_pend;
`endif

    csr_args #(
        .HOST_ADDR_BITS (8),
        .HOST_DATA_BITS (32),
        .NUM_ARGS       (NARGS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .host_req_valid  (host_req_valid),
        .host_req_opcode (host_req_opcode),
        .host_req_addr   (host_req_addr),
        .host_req_value  (host_req_value),
        .host_req_deq    (host_req_deq),
        .host_resp_valid (host_resp_valid),
        .host_resp_bits  (host_resp_bits),
        .launch          (launch),
        .finish          (finish),
        .args            (args),
        .irq             (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_read = 0; m_launch = 0; m_fin = 0; m_cycles = 32'h0;
        m_resp_valid = 0; m_resp_bits = 32'h0;
        for (int k = 0; k < NARGS; k++) m_args[k] = 32'h0;
`ifdef CSR_ARGS_IRQ_EN
        m_irq_en = 0; m_pend = 0;
`endif
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] v;
        int k;
        v = 32'h0;
        k = (int'(a) - 8) / 4;
        if (a[1:0] != 2'b00) return 32'h0;
        if (a == 8'h00) begin
            v[0] = m_launch; v[1] = m_fin; v[2] = m_launch;
`ifdef CSR_ARGS_IRQ_EN
            v[3] = m_irq_en; v[4] = m_pend;
`endif
            return v;
        end
        if (a == 8'h04) return m_cycles;
        if (a >= 8'h08 && k < NARGS) return m_args[k];
        return 32'h0;
    endfunction

    // One clock with the currently driven inputs; model follows the register rules, then outputs are compared.
    task automatic tick();
        bit acc, wr, rd, fin, rst;
        logic [7:0]   a;
        logic [31:0]  v, rdv;
        logic [127:0] exp_args;
        int k;
        bit exp_irq;
        #1;
        acc = host_req_valid && !m_read;
        check("deq", 128'(host_req_deq), 128'(acc));
        wr  = acc && host_req_opcode;
        rd  = acc && !host_req_opcode;
        a   = host_req_addr;
        v   = host_req_value;
        fin = finish;
        rst = reset;
        rdv = model_read(a);
        @(posedge clock);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (m_launch && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
            if (wr && a == 8'h00) begin
                if (v[1]) m_fin = 0;
                if (v[0] && !m_launch && !fin) begin
                    m_launch = 1; m_fin = 0; m_cycles = 32'h0;
                end
`ifdef CSR_ARGS_IRQ_EN
                m_irq_en = v[3];
                if (v[4]) m_pend = 0;
`endif
            end
            k = (int'(a) - 8) / 4;
            if (wr && a[1:0] == 2'b00 && a >= 8'h08 && k < NARGS) m_args[k] = v;
            if (fin) begin
                m_launch = 0; m_fin = 1;
`ifdef CSR_ARGS_IRQ_EN
                m_pend = 1;
`endif
            end
            m_resp_valid = rd;
            if (rd) m_resp_bits = rdv;
            m_read = rd;
        end
        for (int j = 0; j < NARGS; j++) exp_args[j*32 +: 32] = m_args[j];
`ifdef CSR_ARGS_IRQ_EN
        exp_irq = m_pend && m_irq_en;
`else
        exp_irq = 0;
`endif
        check("resp_valid", 128'(host_resp_valid), 128'(m_resp_valid));
        if (m_resp_valid) check("resp_bits", 128'(host_resp_bits), 128'(m_resp_bits));
        check("launch", 128'(launch), 128'(m_launch));
        check("irq", 128'(irq), 128'(exp_irq));
        check("args", 128'(args), exp_args);
    endtask

    task automatic wr_op(input logic [7:0] a, input logic [31:0] v);
        host_req_valid = 1; host_req_opcode = 1; host_req_addr = a; host_req_value = v;
        tick();
        host_req_valid = 0;
    endtask

    task automatic rd_op(input string tag, input logic [7:0] a, input logic [31:0] exp);
        host_req_valid = 1; host_req_opcode = 0; host_req_addr = a;
        tick();
        host_req_valid = 0;
        check(tag, 128'(host_resp_bits), 128'(exp));
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

`ifdef CSR_ARGS_IRQ_EN
    localparam logic [31:0] CTRL_DONE    = 32'h12;
    localparam logic [31:0] CTRL_CLEARED = 32'h10;
`else
    localparam logic [31:0] CTRL_DONE    = 32'h02;
    localparam logic [31:0] CTRL_CLEARED = 32'h00;
`endif

    initial begin
        model_reset();
        reset = 1;
        idle(3);
        reset = 0;
        check("reset_resp_bits", 128'(host_resp_bits), 128'(0));

        rd_op("rd_ctrl_reset", 8'h00, 32'h0);
        rd_op("rd_cycles_reset", 8'h04, 32'h0);
        rd_op("rd_arg0_reset", 8'h08, 32'h0);

        wr_op(8'h0C, 32'hDEADBEEF);
        rd_op("rd_arg1", 8'h0C, 32'hDEADBEEF);
        check("args_arg1", 128'(args[63:32]), 128'(32'hDEADBEEF));
        rd_op("rd_unaligned", 8'h0A, 32'h0);
        rd_op("rd_out_of_range", 8'h40, 32'h0);
        wr_op(8'h0A, 32'h11111111);
        wr_op(8'h40, 32'h22222222);
        wr_op(8'h04, 32'h33333333);
        check("args_unchanged", 128'(args), {64'h0, 32'hDEADBEEF, 32'h0});
        rd_op("rd_cycles_ro", 8'h04, 32'h0);

        // Run: launch high 10 cycles, then finish
        wr_op(8'h00, 32'h1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("launch_held", 128'(launch), 128'(1));
        end
        finish = 1; tick(); finish = 0;
        check("launch_dropped", 128'(launch), 128'(0));
        idle(2);
        rd_op("rd_cycles_10", 8'h04, 32'd10);
        rd_op("rd_ctrl_done", 8'h00, CTRL_DONE);
        wr_op(8'h00, 32'h2);
        rd_op("rd_ctrl_w1c", 8'h00, CTRL_CLEARED);

        // Launch while busy must not restart the counter
        wr_op(8'h00, 32'h1);
        idle(4);
        wr_op(8'h00, 32'h1);
        idle(4);
        finish = 1; tick(); finish = 0;
        rd_op("rd_cycles_norestart", 8'h04, 32'd10);

        // CTRL write colliding with finish, busy and idle
        wr_op(8'h00, 32'h1);
        idle(3);
        finish = 1; wr_op(8'h00, 32'h3); finish = 0;
        check("collide_busy_launch", 128'(launch), 128'(0));
        rd_op("rd_ctrl_collide", 8'h00, CTRL_DONE);
        finish = 1; wr_op(8'h00, 32'h1); finish = 0;
        check("collide_idle_launch", 128'(launch), 128'(0));
        rd_op("rd_ctrl_collide_idle", 8'h00, CTRL_DONE);

        // Back-to-back read then write with valid held
        host_req_valid = 1; host_req_opcode = 0; host_req_addr = 8'h08;
        tick();
        host_req_opcode = 1; host_req_addr = 8'h10; host_req_value = 32'h12345678;
        #1;
        check("deq_low_in_read", 128'(host_req_deq), 128'(0));
        tick();
        tick();
        host_req_valid = 0;
        check("b2b_write", 128'(args[95:64]), 128'(32'h12345678));
        idle(1);

`ifdef CSR_ARGS_IRQ_EN
        wr_op(8'h00, 32'h9);
        idle(3);
        finish = 1; tick(); finish = 0;
        check("irq_set", 128'(irq), 128'(1));
        wr_op(8'h00, 32'h18);
        check("irq_cleared", 128'(irq), 128'(0));
        wr_op(8'h00, 32'h1);
        idle(2);
        finish = 1; tick(); finish = 0;
        check("irq_masked", 128'(irq), 128'(0));
        rd_op("rd_ctrl_pend", 8'h00, 32'h12);
`else
        wr_op(8'h00, 32'h18);
        rd_op("rd_ctrl_irq_bits", 8'h00, 32'h02);
        check("irq_tied", 128'(irq), 128'(0));
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            host_req_valid  = ($urandom_range(0, 3) != 0);
            host_req_opcode = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       host_req_addr = 8'h00;
                1:       host_req_addr = 8'h04;
                2, 3:    host_req_addr = 8'(8 + 4 * $urandom_range(0, NARGS - 1));
                4:       host_req_addr = 8'($urandom_range(0, 255));
                default: host_req_addr = 8'(8 + 4 * NARGS);
            endcase
            host_req_value = (host_req_addr == 8'h00) ? 32'($urandom_range(0, 31)) : $urandom;
            finish = ($urandom_range(0, 15) == 0);
            reset  = ($urandom_range(0, 299) == 0);
            tick();
        end
        host_req_valid = 0; finish = 0; reset = 0;
        idle(2);

        // Reset on the accepting edge drops the response
        host_req_valid = 1; host_req_opcode = 0; host_req_addr = 8'h0C; reset = 1;
        tick();
        host_req_valid = 0; reset = 0;
        check("reset_drops_resp", 128'(host_resp_valid), 128'(0));
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_args.md
Name: csr_args

Overview:
- Parametrised successor of the accelerator host CSR file.
- Sits between the host request/response port and the accelerator core.
- Provides a control/status register, an internally generated run-cycle counter, and NUM_ARGS generic 32-bit argument registers (lengths, buffer addresses) exported as a flat vector.
- Adds busy tracking, write-1-to-clear finish, launch-while-busy protection and address-error handling.

Parameters:
- HOST_ADDR_BITS, 8: host address width; byte addresses, word-aligned.
- HOST_DATA_BITS, 32: register and data width.
- NUM_ARGS, 4: number of argument registers. Legal range 1..(2^HOST_ADDR_BITS/4 - 2); elaboration error outside it.

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- host_req_valid  input  1  host request present
- host_req_opcode  input  1  1 = write, 0 = read
- host_req_addr  input  HOST_ADDR_BITS  byte address
- host_req_value  input  HOST_DATA_BITS  write data
- host_req_deq  output  1  request accepted this cycle
- host_resp_valid  output  1  read data valid
- host_resp_bits  output  HOST_DATA_BITS  read data
- launch  output  1  accelerator run request (level)
- finish  input  1  accelerator done (single-cycle pulse)
- args  output  NUM_ARGS*HOST_DATA_BITS  arg k at bits [k*HOST_DATA_BITS +: HOST_DATA_BITS]
- irq  output  1  interrupt (see Optional Feature)

Behaviour:
- Address map:
  - 0x00: CTRL. bit0 launch (RW), bit1 finish (W1C), bit2 busy (RO, equals launch).
  - 0x04: CYCLES (RO).
  - 0x08 + 4*k: ARG k.
  - Any other address, or any address with addr[1:0] != 0, is invalid.
- FSM states: IDLE, READ.
  - IDLE: host_req_deq = host_req_valid. A read moves to READ; a write stays in IDLE.
  - READ: host_req_deq = 0, host_resp_valid = 1, then return to IDLE.
- Read latency is exactly 1 cycle. Read data is captured at acceptance, so a write cannot land between capture and response.
- Writes take effect on the clock edge that accepts them. No response is produced for a write.
- Invalid address: write ignored; read returns 0 with normal response timing.
- CTRL write:
  - value bit0 = 1 while not busy: launch <= 1, finish bit <= 0, CYCLES <= 0.
  - value bit0 = 1 while busy: ignored (no restart).
  - value bit0 = 0: does not clear launch; the host cannot abort.
  - value bit1 = 1: clears the finish bit.
- finish pulse: launch <= 0, finish bit <= 1. finish has priority over a same-cycle CTRL write; that write's launch bit is dropped.
- finish while not busy: still sets the finish bit (sticky).
- CYCLES:
  - Increments by 1 on every cycle while busy, including the first cycle after launch.
  - Frozen when idle.
  - Saturates at all-ones; no wrap.
  - Writes to CYCLES are ignored.
- ARG registers are RW. Writes while busy are accepted; the core is responsible for sampling args at launch.
- Reset values: all registers 0, launch 0, irq 0, host_resp_valid 0, host_resp_bits 0, state IDLE. Reset mid-read drops the pending response.

Optional Feature:
- Macro: CSR_ARGS_IRQ_EN.
- Defined:
  - CTRL bit3 irq_en (RW), bit4 irq_pending (W1C).
  - irq_pending is set on a finish pulse; set takes priority over a same-cycle clear.
  - irq = irq_pending & irq_en, registered output.
- Undefined: bits 3 and 4 read 0 and ignore writes; irq tied to 0.

Decomposition:
- Package csr_args_pkg holds:
  - state_t enum {IDLE, READ}.
  - Address constants CTRL_ADDR = 0x00, CYCLES_ADDR = 0x04, ARG_BASE = 0x08.
  - CTRL bit-index constants.
- One sub-module, csr_args_decode (combinational): maps addr to {is_ctrl, is_cycles, arg_sel one-hot, valid}. Shared by the write-enable and read-mux paths.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08 -> each response is 0, host_resp_valid exactly 1 cycle after deq.
- Write 0x0C = 0xDEADBEEF, read 0x0C -> 0xDEADBEEF; args[63:32] = 0xDEADBEEF. Read 0x0A (unaligned) and 0x40 (out of range) -> 0; no register changes.
- Write CTRL = 1, hold finish low 10 cycles, then pulse finish:
  - launch high 10 cycles, then low.
  - CYCLES reads 10.
  - CTRL reads 0x2. Write CTRL = 0x2, then CTRL reads 0x0.
- Write CTRL = 1 while busy at cycle 5 -> CYCLES not reset, final count still 10. CTRL write in the same cycle as the finish pulse -> launch 0, finish bit 1.
- Issue back-to-back read then write with host_req_valid held high -> deq low during READ; the write is accepted on the next cycle.
- CSR_ARGS_IRQ_EN defined:
  - irq_en = 1, run to finish -> irq high one cycle after the finish pulse.
  - Write CTRL bit4 -> irq low.
  - With irq_en = 0, irq stays low but irq_pending reads 1.
